// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches {op, operand} words, drives the external ALU,
// keeps the accumulator, and handles jumps, calls/returns and LD/ST traffic.
module instr_sequencer #(
    parameter int WIDTH       = 16,
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    output logic [ADDR_W-1:0]    pc_addr,
    input  logic [8+WIDTH-1:0]   instr_in,
    output logic [ADDR_W-1:0]    dmem_addr,
    output logic [WIDTH-1:0]     dmem_wdata,
    output logic                 dmem_we,
    input  logic [WIDTH-1:0]     dmem_rdata,
    output logic [7:0]           alu_op,
    output logic [WIDTH-1:0]     alu_in1,
    output logic [WIDTH-1:0]     alu_in2,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_overflow,
    output logic [WIDTH-1:0]     acc,
    output logic                 ovf_flag,
    output logic                 stack_err,
    output logic                 halted,
    output logic [2:0]           state_dbg
);

    // Opcode values mirror the shared instruction definitions used by the ALU.
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_NOT = 8'h01;
    localparam logic [7:0] OP_XOR = 8'h02;
    localparam logic [7:0] OP_OR  = 8'h03;
    localparam logic [7:0] OP_AND = 8'h04;
    localparam logic [7:0] OP_SUB = 8'h05;
    localparam logic [7:0] OP_ADD = 8'h06;
    localparam logic [7:0] OP_RR  = 8'h07;
    localparam logic [7:0] OP_RL  = 8'h08;
    localparam logic [7:0] OP_DEC = 8'h09;
    localparam logic [7:0] OP_INC = 8'h0A;
    localparam logic [7:0] OP_LDI = 8'h0B;
    localparam logic [7:0] OP_LD  = 8'h0C;
    localparam logic [7:0] OP_ST  = 8'h0D;
    localparam logic [7:0] OP_JMP = 8'h0E;
    localparam logic [7:0] OP_JMA = 8'h0F;
    localparam logic [7:0] OP_CLL = 8'h10;
    localparam logic [7:0] OP_RET = 8'h11;
    localparam logic [7:0] OP_RST = 8'h12;

    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt, pc_inc, target;
    logic [WIDTH-1:0]    acc_nxt;
    logic [8+WIDTH-1:0]  ir;
    logic [7:0]          op;
    logic [WIDTH-1:0]    operand;
    logic [SP_W-1:0]     sp, sp_nxt;
    logic [SP_W-2:0]     top_idx;
    logic [ADDR_W-1:0]   stack [STACK_DEPTH];
    logic                push;
    logic                ovf_nxt, err_nxt;

    assign op        = ir[8+WIDTH-1:WIDTH];
    assign operand   = ir[WIDTH-1:0];
    assign target    = operand[ADDR_W-1:0];
    assign pc_inc    = pc + 1'b1;
    assign top_idx   = sp[SP_W-2:0] - 1'b1;
    assign pc_addr   = pc;
    assign halted    = (state == S_HALT);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            acc       <= '0;
            ir        <= '0;
            sp        <= '0;
            ovf_flag  <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            acc       <= acc_nxt;
            sp        <= sp_nxt;
            ovf_flag  <= ovf_nxt;
            stack_err <= err_nxt;
            if (state == S_DECODE) ir <= instr_in;
        end
    end

    // Stack entries carry no reset: sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) stack[sp[SP_W-2:0]] <= pc_inc;
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        acc_nxt    = acc;
        sp_nxt     = sp;
        ovf_nxt    = ovf_flag;
        err_nxt    = stack_err;
        push       = 1'b0;
        alu_op     = OP_NOP;
        alu_in1    = acc;
        alu_in2    = operand;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_we    = 1'b0;

        case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = run ? S_DECODE : S_IDLE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                alu_op    = op;
                state_nxt = S_FETCH;
                pc_nxt    = pc_inc;
                case (op)
                    OP_NOT, OP_XOR, OP_OR, OP_AND, OP_SUB,
                    OP_ADD, OP_RR, OP_RL, OP_DEC, OP_INC: begin
                        acc_nxt = alu_out;
                        if (op == OP_ADD || op == OP_SUB || op == OP_INC || op == OP_DEC)
                            ovf_nxt = alu_overflow;
                    end
                    OP_LDI: begin
                        alu_in1 = operand;
                        acc_nxt = alu_out;
                    end
                    OP_LD: begin
                        dmem_addr = target;
                        pc_nxt    = pc;
                        state_nxt = S_MEM;
                    end
                    OP_ST: begin
                        dmem_addr  = target;
                        dmem_wdata = acc;
                        // Gated by reset so a reset landing on this cycle cancels the write.
                        dmem_we    = rst_n;
                    end
                    OP_JMP: pc_nxt = target;
                    OP_JMA: if (acc == '0) pc_nxt = target;
                    OP_CLL: begin
                        if (sp == SP_FULL) begin
                            err_nxt   = 1'b1;
                            pc_nxt    = pc;
                            state_nxt = S_HALT;
                        end else begin
                            push   = 1'b1;
                            sp_nxt = sp + 1'b1;
                            pc_nxt = target;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            err_nxt   = 1'b1;
                            pc_nxt    = pc;
                            state_nxt = S_HALT;
                        end else begin
                            pc_nxt = stack[top_idx];
                            sp_nxt = sp - 1'b1;
                        end
                    end
                    OP_RST: begin
                        acc_nxt = '0;
                        pc_nxt  = '0;
                        sp_nxt  = '0;
                        ovf_nxt = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                alu_op    = op;
                alu_in2   = dmem_rdata;
                dmem_addr = target;
                acc_nxt   = alu_out;
                pc_nxt    = pc_inc;
                state_nxt = S_FETCH;
            end
            S_HALT: ;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: table of single-instruction vectors, hand-written
// multi-cycle sequences, and random programs against an instruction-level model.
module tb_instr_sequencer;

    localparam logic [7:0] OP_NOP = 8'h00, OP_NOT = 8'h01, OP_XOR = 8'h02, OP_OR  = 8'h03;
    localparam logic [7:0] OP_AND = 8'h04, OP_SUB = 8'h05, OP_ADD = 8'h06, OP_RR  = 8'h07;
    localparam logic [7:0] OP_RL  = 8'h08, OP_DEC = 8'h09, OP_INC = 8'h0A, OP_LDI = 8'h0B;
    localparam logic [7:0] OP_LD  = 8'h0C, OP_ST  = 8'h0D, OP_JMP = 8'h0E, OP_JMA = 8'h0F;
    localparam logic [7:0] OP_CLL = 8'h10, OP_RET = 8'h11, OP_RST = 8'h12;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, run;
    logic [7:0]  pc_addr, dmem_addr, alu_op;
    logic [23:0] instr_in;
    logic [15:0] dmem_wdata, dmem_rdata, alu_in1, alu_in2, alu_out, acc;
    logic        dmem_we, alu_overflow, ovf_flag, stack_err, halted;
    logic [2:0]  state_dbg;

    instr_sequencer #(.WIDTH(16), .ADDR_W(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .pc_addr(pc_addr), .instr_in(instr_in),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_overflow(alu_overflow), .acc(acc), .ovf_flag(ovf_flag),
        .stack_err(stack_err), .halted(halted), .state_dbg(state_dbg)
    );

    // ---------------- memories and ALU fixture ----------------
    logic [23:0] pmem [256];
    logic [15:0] dmem [256];
    logic [15:0] m_dmem [256];

    always @(posedge clk) begin
        instr_in   <= pmem[pc_addr];
        dmem_rdata <= dmem[dmem_addr];
    end

    always_comb begin
        logic [15:0] r;
        r = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            OP_NOT: r = ~alu_in1;
            OP_XOR: r = alu_in1 ^ alu_in2;
            OP_OR:  r = alu_in1 | alu_in2;
            OP_AND: r = alu_in1 & alu_in2;
            OP_ADD: begin
                r = alu_in1 + alu_in2;
                alu_overflow = (alu_in1[15] == alu_in2[15]) && (r[15] != alu_in1[15]);
            end
            OP_SUB: begin
                r = alu_in1 - alu_in2;
                alu_overflow = (alu_in1[15] != alu_in2[15]) && (r[15] != alu_in1[15]);
            end
            OP_RR:  r = {alu_in1[0], alu_in1[15:1]};
            OP_RL:  r = {alu_in1[14:0], alu_in1[15]};
            OP_INC: begin r = alu_in1 + 16'd1; alu_overflow = (alu_in1 == 16'h7FFF); end
            OP_DEC: begin r = alu_in1 - 16'd1; alu_overflow = (alu_in1 == 16'h8000); end
            OP_LDI: r = alu_in1;
            OP_LD:  r = alu_in2;
            default: r = '0;
        endcase
        alu_out = r;
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory write is taken just before the edge, with the strobe as it stands then.
    task automatic tick();
        if (dmem_we) dmem[dmem_addr] = dmem_wdata;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            pmem[i] = {OP_NOP, 16'h0000};
            dmem[i] = '0;
        end
    endtask

    task automatic do_reset(input logic r);
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run   = r;
        cyc   = -1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " pc_addr"},    pc_addr, 0);
        check({tag, " dmem_addr"},  dmem_addr, 0);
        check({tag, " dmem_wdata"}, dmem_wdata, 0);
        check({tag, " dmem_we"},    dmem_we, 0);
        check({tag, " alu_op"},     alu_op, OP_NOP);
        check({tag, " alu_in1"},    alu_in1, 0);
        check({tag, " alu_in2"},    alu_in2, 0);
        check({tag, " acc"},        acc, 0);
        check({tag, " ovf_flag"},   ovf_flag, 0);
        check({tag, " stack_err"},  stack_err, 0);
        check({tag, " halted"},     halted, 0);
    endtask

    // ---------------- instruction-level reference model ----------------
    int          f_cycle [$];
    logic [7:0]  f_pc    [$];
    logic [15:0] f_acc   [$];
    logic        f_ovf   [$];
    logic [39:0] exp_q   [$];   // {cycle[15:0], addr[7:0], data[15:0]}
    int          m_halt_c;

    task automatic model_run(input int n);
        logic [7:0]  pc, nxt;
        logic [15:0] a, opnd;
        logic [7:0]  op;
        logic        ovf;
        logic [7:0]  stk [$];
        int          t, lat, s;
        pc = 0; a = 0; ovf = 0; t = 0; m_halt_c = -1;
        f_cycle.delete(); f_pc.delete(); f_acc.delete(); f_ovf.delete(); exp_q.delete();
        for (int k = 0; k <= n; k++) begin
            f_cycle.push_back(t); f_pc.push_back(pc); f_acc.push_back(a); f_ovf.push_back(ovf);
            if (k == n) break;
            op   = pmem[pc][23:16];
            opnd = pmem[pc][15:0];
            nxt  = pc + 8'd1;
            lat  = 3;
            case (op)
                OP_NOT: a = ~a;
                OP_XOR: a = a ^ opnd;
                OP_OR:  a = a | opnd;
                OP_AND: a = a & opnd;
                OP_ADD: begin s = $signed(a) + $signed(opnd); a = 16'(s); ovf = (s > 32767) || (s < -32768); end
                OP_SUB: begin s = $signed(a) - $signed(opnd); a = 16'(s); ovf = (s > 32767) || (s < -32768); end
                OP_INC: begin s = $signed(a) + 1; a = 16'(s); ovf = (s > 32767); end
                OP_DEC: begin s = $signed(a) - 1; a = 16'(s); ovf = (s < -32768); end
                OP_RR:  a = (a >> 1) | (a << 15);
                OP_RL:  a = (a << 1) | (a >> 15);
                OP_LDI: a = opnd;
                OP_LD:  begin a = m_dmem[opnd[7:0]]; lat = 4; end
                OP_ST:  begin exp_q.push_back({16'(t + 2), opnd[7:0], a}); m_dmem[opnd[7:0]] = a; end
                OP_JMP: nxt = opnd[7:0];
                OP_JMA: if (a == 0) nxt = opnd[7:0];
                OP_CLL: if (stk.size() == 4) begin m_halt_c = t + 2; break; end
                        else begin stk.push_back(nxt); nxt = opnd[7:0]; end
                OP_RET: if (stk.size() == 0) begin m_halt_c = t + 2; break; end
                        else nxt = stk.pop_back();
                OP_RST: begin a = 0; nxt = 0; ovf = 0; stk.delete(); end
                default: ;
            endcase
            t  = t + lat;
            pc = nxt;
        end
    endtask

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 23))
            0: return OP_NOP;  1: return OP_NOT;  2: return OP_XOR;  3: return OP_OR;
            4: return OP_AND;  5: return OP_SUB;  6: return OP_ADD;  7: return OP_RR;
            8: return OP_RL;   9: return OP_DEC; 10: return OP_INC; 11: return OP_LDI;
            12: return OP_LDI; 13: return OP_LD; 14: return OP_ST;  15: return OP_ST;
            16: return OP_JMP; 17: return OP_JMA; 18: return OP_CLL; 19: return OP_RET;
            20: return OP_RST; 21: return OP_ADD; 22: return 8'hEE;
            default: return OP_INC;
        endcase
    endfunction

    task automatic run_random(input int n);
        int end_c, fi;
        logic exp_we;
        for (int i = 0; i < 256; i++) begin
            pmem[i]   = {rand_op(), 16'($urandom)};
            dmem[i]   = 16'($urandom);
            m_dmem[i] = dmem[i];
        end
        model_run(n);
        do_reset(1'b1);
        end_c = (m_halt_c >= 0) ? m_halt_c + 4 : f_cycle[f_cycle.size()-1];
        fi = 0;
        while (cyc < end_c) begin
            tick();
            if (fi < f_cycle.size() && cyc == f_cycle[fi]) begin
                check("rnd fetch pc", pc_addr, f_pc[fi]);
                check("rnd acc",      acc,     f_acc[fi]);
                check("rnd ovf",      ovf_flag, f_ovf[fi]);
                check("rnd halted",   halted,  0);
                fi++;
            end
            exp_we = (exp_q.size() > 0) && (int'(exp_q[0][39:24]) == cyc);
            check("rnd dmem_we", dmem_we, exp_we);
            if (exp_we) begin
                check("rnd st addr", dmem_addr, exp_q[0][23:16]);
                check("rnd st data", dmem_wdata, exp_q[0][15:0]);
                void'(exp_q.pop_front());
            end
            if (m_halt_c >= 0 && cyc > m_halt_c) begin
                check("rnd halt halted",    halted, 1);
                check("rnd halt stack_err", stack_err, 1);
                check("rnd halt pc held",   pc_addr, f_pc[f_pc.size()-1]);
            end
        end
        check("rnd all fetches seen", fi, f_cycle.size());
    endtask

    // ---------------- single-instruction vector table ----------------
    typedef struct {
        logic [7:0]  op;
        logic [15:0] a;        // loaded by LDI first
        logic [15:0] b;        // operand of the instruction under test
        logic [15:0] exp_acc;
        logic        exp_ovf;
        logic [7:0]  exp_pc;
    } vec_t;

    vec_t vecs [19];

    initial begin
        vecs = '{
            '{OP_ADD, 16'h0005, 16'h0003, 16'h0008, 1'b0, 8'h02},
            '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 8'h02},
            '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 8'h02},
            '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 8'h02},
            '{OP_INC, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 8'h02},
            '{OP_DEC, 16'h8000, 16'h0000, 16'h7FFF, 1'b1, 8'h02},
            '{OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 8'h02},
            '{OP_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 8'h02},
            '{OP_OR,  16'h1200, 16'h0034, 16'h1234, 1'b0, 8'h02},
            '{OP_AND, 16'hABCD, 16'h0FF0, 16'h0BC0, 1'b0, 8'h02},
            '{OP_RR,  16'h0001, 16'h0000, 16'h8000, 1'b0, 8'h02},
            '{OP_RL,  16'h8001, 16'h0000, 16'h0003, 1'b0, 8'h02},
            '{OP_LDI, 16'h0001, 16'hCAFE, 16'hCAFE, 1'b0, 8'h02},
            '{OP_NOP, 16'h1234, 16'h5678, 16'h1234, 1'b0, 8'h02},
            '{8'hEE,  16'h5555, 16'h1111, 16'h5555, 1'b0, 8'h02},
            '{OP_JMP, 16'h4321, 16'h01AB, 16'h4321, 1'b0, 8'hAB},
            '{OP_JMA, 16'h0000, 16'h0040, 16'h0000, 1'b0, 8'h40},
            '{OP_JMA, 16'h0001, 16'h0040, 16'h0001, 1'b0, 8'h02},
            '{OP_RST, 16'h1234, 16'h0000, 16'h0000, 1'b0, 8'h00}
        };
    end

    // ---------------- main sequence ----------------
    initial begin
        int we_cnt;
        rst_n = 1'b0;
        run   = 1'b0;
        clear_mem();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");

        // Table vectors: LDI a at 0, instruction at 1, result visible at third fetch.
        foreach (vecs[i]) begin
            clear_mem();
            pmem[0] = {OP_LDI, vecs[i].a};
            pmem[1] = {vecs[i].op, vecs[i].b};
            do_reset(1'b1);
            run_to(6);
            check($sformatf("vec%0d pc", i),  pc_addr,  vecs[i].exp_pc);
            check($sformatf("vec%0d acc", i), acc,      vecs[i].exp_acc);
            check($sformatf("vec%0d ovf", i), ovf_flag, vecs[i].exp_ovf);
        end

        // Arithmetic then store: one write strobe, 3-cycle fetch spacing.
        clear_mem();
        pmem[0] = {OP_LDI, 16'h0005};
        pmem[1] = {OP_ADD, 16'h0003};
        pmem[2] = {OP_ST,  16'h0010};
        pmem[3] = {OP_JMP, 16'h0003};
        do_reset(1'b1);
        we_cnt = 0;
        for (int c = 0; c <= 14; c++) begin
            run_to(c);
            if (c == 3) check("st second fetch pc", pc_addr, 8'h01);
            if (dmem_we) we_cnt++;
            if (c == 8) begin
                check("st we", dmem_we, 1);
                check("st addr", dmem_addr, 8'h10);
                check("st wdata", dmem_wdata, 16'h0008);
            end
        end
        check("st we count", we_cnt, 1);
        check("st mem", dmem[16], 16'h0008);

        // Load: acc changes only after the MEM cycle.
        clear_mem();
        dmem[8'h20] = 16'hBEEF;
        pmem[0] = {OP_LD, 16'h0020};
        do_reset(1'b1);
        we_cnt = 0;
        for (int c = 0; c <= 4; c++) begin
            run_to(c);
            if (dmem_we) we_cnt++;
            if (c == 3) check("ld acc before", acc, 16'h0000);
        end
        check("ld next pc", pc_addr, 8'h01);
        check("ld acc", acc, 16'hBEEF);
        check("ld no we", we_cnt, 0);

        // Call and return.
        clear_mem();
        pmem[2]     = {OP_CLL, 16'h0030};
        pmem[8'h30] = {OP_RET, 16'h0000};
        do_reset(1'b1);
        run_to(9);
        check("cll target", pc_addr, 8'h30);
        run_to(12);
        check("ret resume", pc_addr, 8'h03);
        check("ret no err", stack_err, 0);

        // Five nested calls overflow a 4-deep stack.
        clear_mem();
        pmem[8'h00] = {OP_CLL, 16'h0010};
        pmem[8'h10] = {OP_CLL, 16'h0020};
        pmem[8'h20] = {OP_CLL, 16'h0030};
        pmem[8'h30] = {OP_CLL, 16'h0040};
        pmem[8'h40] = {OP_CLL, 16'h0050};
        do_reset(1'b1);
        run_to(12);
        check("cll4 pc", pc_addr, 8'h40);
        run_to(14);
        check("cll5 not yet halted", halted, 0);
        run_to(15);
        check("cll5 halted", halted, 1);
        check("cll5 stack_err", stack_err, 1);
        run_to(30);
        check("cll5 no fetch", pc_addr, 8'h40);
        check("cll5 still halted", halted, 1);

        // RET on empty stack.
        clear_mem();
        pmem[0] = {OP_RET, 16'h0000};
        do_reset(1'b1);
        run_to(3);
        check("ret empty halted", halted, 1);
        check("ret empty err", stack_err, 1);

        // pc wraps from 0xFF to 0x00.
        clear_mem();
        pmem[0]     = {OP_JMP, 16'h00FF};
        pmem[8'hFF] = {OP_NOP, 16'h0000};
        do_reset(1'b1);
        run_to(3);
        check("wrap at ff", pc_addr, 8'hFF);
        run_to(6);
        check("wrap to 00", pc_addr, 8'h00);

        // Reset lands on the ST execute cycle.
        clear_mem();
        dmem[8'h11] = 16'hAAAA;
        pmem[0] = {OP_LDI, 16'h0007};
        pmem[1] = {OP_ST,  16'h0011};
        do_reset(1'b1);
        run_to(5);
        check("rst st we before", dmem_we, 1);
        rst_n = 1'b0;
        #1;
        check("rst st we gated", dmem_we, 0);
        tick();
        check("rst st no write", dmem[8'h11], 16'hAAAA);
        check_reset_vals("rst mid st");

        // Pause mid-instruction: completes, then idles with pc held.
        clear_mem();
        pmem[0] = {OP_LDI, 16'h0009};
        pmem[1] = {OP_ADD, 16'h0001};
        do_reset(1'b1);
        run_to(1);
        run = 1'b0;
        run_to(10);
        check("pause pc held", pc_addr, 8'h01);
        check("pause acc", acc, 16'h0009);
        run = 1'b1;
        run_to(14);
        check("resume pc", pc_addr, 8'h02);
        check("resume acc", acc, 16'h000A);

        // Random programs against the model.
        for (int p = 0; p < 30; p++) run_random(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Control-side counterpart of the 16-bit ALU: fetches instruction words from program memory, decodes the 8-bit opcode and drives the ALU's op and operand inputs.
- Writes ALU results back into an accumulator, and handles jumps, calls/returns and LD/ST data-memory traffic.
- Opcode encodings come from the shared src/control/instructions.v definitions.
- Sits between program memory, data memory and the ALU in the CPU core.

Parameters:
WIDTH, 16, datapath and accumulator width (matches ALU WIDTH)
ADDR_W, 8, program and data memory address width
STACK_DEPTH, 4, call-stack entries (power of 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
run  input  1  1 = execute; sampled in IDLE and at every FETCH entry
pc_addr  output  ADDR_W  program memory address
instr_in  input  8+WIDTH  {op[7:0], operand[WIDTH-1:0]}; valid one cycle after pc_addr
dmem_addr  output  ADDR_W  data memory address (operand[ADDR_W-1:0])
dmem_wdata  output  WIDTH  store data (= acc)
dmem_we  output  1  one-cycle write strobe
dmem_rdata  input  WIDTH  load data; valid one cycle after dmem_addr
alu_op  output  8  opcode to ALU
alu_in1  output  WIDTH  acc; operand during LDI
alu_in2  output  WIDTH  operand; dmem_rdata during LD MEM state
alu_out  input  WIDTH  ALU result (combinational)
alu_overflow  input  1  ALU overflow
acc  output  WIDTH  accumulator
ovf_flag  output  1  latched overflow from last ADD/SUB/INC/DEC
stack_err  output  1  sticky call-stack over/underflow
halted  output  1  1 in HALT state

Behaviour:
- Reset values:
  - State IDLE; pc, acc, ir, stack pointer = 0.
  - pc_addr, dmem_addr, dmem_wdata, alu_in1, alu_in2 = 0; alu_op = `NOP.
  - dmem_we, ovf_flag, stack_err, halted = 0.
  - Reset wins over any in-flight operation; dmem_we is 0 from the reset edge onward.
- States:
  - IDLE → FETCH when run=1.
  - FETCH: drive pc_addr=pc. Go to IDLE if run=0, else DECODE.
  - DECODE: latch ir<=instr_in → EXEC.
  - EXEC: act per opcode → FETCH, except LD → MEM and stack fault → HALT.
  - MEM: acc<=alu_out with alu_op=`LD, alu_in2=dmem_rdata; pc+1 → FETCH.
  - HALT: absorbing; exit only by reset.
- Latency: 3 cycles per instruction; LD takes 4.
- EXEC actions (alu_op=ir.op in EXEC and MEM, `NOP otherwise):
  - NOT/XOR/OR/AND/SUB/ADD/RR/RL/DEC/INC: acc<=alu_out; pc<=pc+1.
  - ovf_flag<=alu_overflow for ADD/SUB/INC/DEC only; other ops leave it unchanged.
  - LDI: alu_in1=operand; acc<=alu_out; pc+1.
  - LD: dmem_addr=operand[ADDR_W-1:0]; acc unchanged until MEM.
  - ST: dmem_addr=operand; dmem_wdata=acc; dmem_we=1 for exactly this cycle; pc+1.
  - JMP: pc<=operand[ADDR_W-1:0].
  - JMA: pc<=operand if acc==0, else pc+1.
  - CLL:
    - Stack not full: push pc+1, pc<=operand.
    - Full: stack_err=1 → HALT, pc and stack unchanged.
  - RET:
    - Stack not empty: pop into pc.
    - Empty: stack_err=1 → HALT.
  - RST: acc<=0; pc<=0; stack pointer<=0; ovf_flag<=0.
  - NOP and any undefined opcode: pc+1 only; acc unchanged.
- Width rules:
  - pc increments modulo 2^ADDR_W (wraps max→0).
  - Jump/call targets truncate operand to ADDR_W bits.
  - acc is exactly WIDTH bits; no carry retained.
- Stack:
  - Full = STACK_DEPTH entries.
  - CLL at depth STACK_DEPTH-1 succeeds; the next CLL faults.
- run deasserted mid-instruction: the current instruction completes; the pause takes effect at the next FETCH.

Test Plan:
- Arithmetic and store: reset, run=1; program LDI 0x0005, ADD 0x0003, ST 0x10 → acc=0x0008. dmem_we high exactly one cycle with addr 0x10, wdata 0x0008. Second instruction fetch is 3 cycles after the first.
- Load: dmem[0x20]=0xBEEF; LD 0x20 → acc=0xBEEF 4 cycles after fetch; dmem_we never asserted.
- Conditional jump: LDI 0, JMA 0x40 → next pc_addr=0x40. LDI 1, JMA 0x40 → next pc_addr=previous+1.
- Call/return: CLL 0x30 at pc=0x02, then RET at 0x30 → fetch resumes at 0x03. Five nested CLL with STACK_DEPTH=4 → 5th sets stack_err=1, halted=1, no further fetches.
- Edge cases:
  - RET on empty stack → stack_err=1, halted=1.
  - NOP at pc=0xFF → next fetch at 0x00.
  - Undefined opcode 0xEE → acc unchanged.
- Reset/pause: rst_n=0 during an ST EXEC cycle → dmem_we=0 that edge, all outputs at reset values. run=0 mid-instruction → instruction completes, then IDLE with pc held.
